// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and synchronizer depth floor.
// Conversions work on a FIFO_PTR_MAX_W-wide word; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

   localparam int FIFO_MIN_SYNC_STAGES = 2;
   localparam int FIFO_PTR_MAX_W       = 32;

   typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

   function automatic fifo_ptr_t bin2gray(input fifo_ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits contribute nothing to the XOR prefix, so any narrower width converts correctly.
   function automatic fifo_ptr_t gray2bin(input fifo_ptr_t g);
      fifo_ptr_t b;
      b = g;
      for (int i = 1; i < FIFO_PTR_MAX_W; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// STAGES-deep flop chain carrying a Gray pointer across clock domains.
// The first flop samples the asynchronous input directly, with no logic in front of it.
module ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain[i] <= '0;
         end
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/rptr_empty_lvl.sv
// Async-FIFO read-side controller: read pointers, synchronized write pointer, empty/almost-empty/level.
// Define RPTR_UNDERFLOW_EN to add the sticky runderflow output.
module rptr_empty_lvl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE    = 4,
   parameter int AE_THRESH   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic [ADDRSIZE:0]   rptr,
   output logic                rempty,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   rlevel
`ifdef RPTR_UNDERFLOW_EN
   ,
   output logic                runderflow
`endif
);

   localparam int PTR_W = ADDRSIZE + 1;

   if (SYNC_STAGES < FIFO_MIN_SYNC_STAGES) begin : g_chk_sync
      $error("rptr_empty_lvl: SYNC_STAGES must be at least FIFO_MIN_SYNC_STAGES");
   end
   if (AE_THRESH < 0 || AE_THRESH >= (1 << ADDRSIZE)) begin : g_chk_ae
      $error("rptr_empty_lvl: AE_THRESH must lie in 0 .. 2**ADDRSIZE-1");
   end

   logic [PTR_W-1:0] rq_wptr;
   logic [PTR_W-1:0] rbin;
   logic [PTR_W-1:0] rbnext;
   logic [PTR_W-1:0] rgnext;
   logic [PTR_W-1:0] wbin_s;
   logic [PTR_W-1:0] lvl_next;
   logic             rd_ok;

   ptr_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (wptr),
      .q     (rq_wptr)
   );

   // Empty and level are judged on the post-read pointer so the last read flags empty on its own edge.
   assign rd_ok    = rinc & ~rempty;
   assign rbnext   = rbin + PTR_W'(rd_ok);
   assign rgnext   = PTR_W'(bin2gray(fifo_ptr_t'(rbnext)));
   assign wbin_s   = PTR_W'(gray2bin(fifo_ptr_t'(rq_wptr)));
   assign lvl_next = wbin_s - rbnext;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin          <= '0;
         rptr          <= '0;
         rempty        <= 1'b1;
         ralmost_empty <= 1'b1;
         rlevel        <= '0;
      end else begin
         rbin          <= rbnext;
         rptr          <= rgnext;
         rempty        <= (rgnext == rq_wptr);
         ralmost_empty <= (lvl_next <= PTR_W'(AE_THRESH));
         rlevel        <= lvl_next;
      end
   end

   assign raddr = rbin[ADDRSIZE-1:0];

`ifdef RPTR_UNDERFLOW_EN
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         runderflow <= 1'b0;
      end else if (rinc && rempty) begin
         runderflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl: an integer read/write-count model checked every cycle,
// plus literal expectations for reset, fill latency, drain, wrap, full level and mid-run reset.
module tb_rptr_empty_lvl;

   localparam int AW = 4;
   localparam int PW = AW + 1;
   localparam int AE = 2;
   localparam int SS = 2;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          rinc;
   logic [PW-1:0] wptr;
   logic [AW-1:0] raddr;
   logic [PW-1:0] rptr;
   logic          rempty;
   logic          ralmost_empty;
   logic [PW-1:0] rlevel;
`ifdef RPTR_UNDERFLOW_EN
   logic          runderflow;
`endif

   int wcount = 0;
   int n_cmp  = 0;
   int n_err  = 0;

   function automatic logic [PW-1:0] to_gray(input int b);
      logic [PW-1:0] x;
      x = b[PW-1:0];
      return x ^ (x >> 1);
   endfunction

   function automatic int lvl(input int w, input int r);
      return (((w - r) % 32) + 32) % 32;
   endfunction

   assign wptr = to_gray(wcount);

   rptr_empty_lvl #(
      .ADDRSIZE    (AW),
      .AE_THRESH   (AE),
      .SYNC_STAGES (SS)
   ) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rinc          (rinc),
      .wptr          (wptr),
      .raddr         (raddr),
      .rptr          (rptr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel)
`ifdef RPTR_UNDERFLOW_EN
      ,
      .runderflow    (runderflow)
`endif
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: total reads and the write count seen S edges late give level; flags follow from level.
   int  pipe [SS];
   int  m_total;
   int  m_level;
   bit  m_empty;
   bit  m_ae;
   bit  m_hon;
   bit  m_uf;

   always @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         m_total <= 0;
         m_level <= 0;
         m_empty <= 1'b1;
         m_ae    <= 1'b1;
         m_hon   <= 1'b0;
         m_uf    <= 1'b0;
         for (int i = 0; i < SS; i++) pipe[i] <= 0;
      end else begin
         m_hon   <= rinc && !m_empty;
         m_total <= m_total + int'(rinc && !m_empty);
         m_level <= lvl(pipe[SS-1], m_total + int'(rinc && !m_empty));
         m_empty <= lvl(pipe[SS-1], m_total + int'(rinc && !m_empty)) == 0;
         m_ae    <= lvl(pipe[SS-1], m_total + int'(rinc && !m_empty)) <= AE;
         if (rinc && m_empty) m_uf <= 1'b1;
         pipe[0] <= wcount % 32;
         for (int i = 1; i < SS; i++) pipe[i] <= pipe[i-1];
      end
   end

   logic [PW-1:0] prev_rptr  = '0;
   logic [AW-1:0] prev_raddr = '0;
   bit            wrap_seen  = 1'b0;

   always @(negedge rclk) begin
      if (rrst_n) begin
         chk("rempty", int'(rempty), int'(m_empty));
         chk("ralmost_empty", int'(ralmost_empty), int'(m_ae));
         chk("rlevel", int'(rlevel), m_level);
         chk("rptr", int'(rptr), int'(to_gray(m_total)));
         chk("raddr", int'(raddr), m_total % 16);
`ifdef RPTR_UNDERFLOW_EN
         chk("runderflow", int'(runderflow), int'(m_uf));
`endif
         if (m_hon) begin
            chk("rptr_onebit", $countones(rptr ^ prev_rptr), 1);
            if (prev_raddr == 4'd15 && raddr == 4'd0) wrap_seen <= 1'b1;
         end
         prev_rptr  <= rptr;
         prev_raddr <= raddr;
      end
   end

   initial begin
      // Reset held with a live write pointer and a read request
      rrst_n = 1'b0;
      rinc   = 1'b1;
      wcount = 12;
      repeat (3) @(posedge rclk);
      #1;
      chk("t1_wptr_drive", int'(wptr), 5'b01010);
      chk("t1_rempty", int'(rempty), 1);
      chk("t1_ae", int'(ralmost_empty), 1);
      chk("t1_rlevel", int'(rlevel), 0);
      chk("t1_rptr", int'(rptr), 0);
      chk("t1_raddr", int'(raddr), 0);
      @(negedge rclk);
      wcount = 0;
      rinc   = 1'b0;
      rrst_n = 1'b1;
      repeat (2) @(posedge rclk);
      #1;
      chk("t1_post_rempty", int'(rempty), 1);
      chk("t1_post_ae", int'(ralmost_empty), 1);
      chk("t1_post_rlevel", int'(rlevel), 0);
      chk("t1_post_rptr", int'(rptr), 0);

      // Fill visibility: three writes appear on the third edge
      @(negedge rclk);
      wcount = 3;
      @(posedge rclk); #1;
      chk("t2_e1_rlevel", int'(rlevel), 0);
      @(posedge rclk); #1;
      chk("t2_e2_rlevel", int'(rlevel), 0);
      chk("t2_e2_rempty", int'(rempty), 1);
      @(posedge rclk); #1;
      chk("t2_e3_rlevel", int'(rlevel), 3);
      chk("t2_e3_rempty", int'(rempty), 0);
      chk("t2_e3_ae", int'(ralmost_empty), 0);

      // Drain with one surplus read
      @(negedge rclk);
      rinc = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge rclk); #1;
         chk("t3_rlevel", int'(rlevel), (i < 3) ? 2 - i : 0);
         chk("t3_ae", int'(ralmost_empty), 1);
         chk("t3_rempty", int'(rempty), (i >= 2) ? 1 : 0);
         chk("t3_raddr", int'(raddr), (i < 3) ? i + 1 : 3);
      end
      @(negedge rclk);
      rinc = 1'b0;

      // Streaming across the pointer wrap
      begin
         int wrote;
         wrote = 0;
         for (int c = 0; c < 300 && m_total < 43; c++) begin
            @(negedge rclk);
            rinc = 1'b1;
            if (wrote < 40) begin
               wcount++;
               wrote++;
            end
         end
         rinc = 1'b0;
      end
      chk("t4_stream_done", m_total, 43);
      @(negedge rclk);
      chk("t4_rptr", int'(rptr), 5'b01110);
      chk("t4_raddr", int'(raddr), 11);
      chk("t4_rempty", int'(rempty), 1);
      chk("t4_raddr_wrap", int'(wrap_seen), 1);

      // Full level and complete drain
      rrst_n = 1'b0;
      wcount = 0;
      @(negedge rclk);
      rrst_n = 1'b1;
      wcount = 16;
      repeat (4) @(posedge rclk);
      #1;
      chk("t5_rlevel", int'(rlevel), 16);
      chk("t5_rempty", int'(rempty), 0);
      chk("t5_ae", int'(ralmost_empty), 0);
      @(negedge rclk);
      rinc = 1'b1;
      repeat (16) @(negedge rclk);
      rinc = 1'b0;
      chk("t5_drain_rlevel", int'(rlevel), 0);
      chk("t5_drain_rptr", int'(rptr), 5'b11000);
      chk("t5_drain_rempty", int'(rempty), 1);

      // Mid-read asynchronous reset, then underflow
      rrst_n = 1'b0;
      wcount = 5;
      @(negedge rclk);
      rrst_n = 1'b1;
      repeat (4) @(posedge rclk);
      #1;
      chk("t6_rlevel", int'(rlevel), 5);
      @(negedge rclk);
      rinc = 1'b1;
      @(posedge rclk); #1;
      chk("t6_read_rlevel", int'(rlevel), 4);
      #1 rrst_n = 1'b0;
      #1;
      chk("t6_async_rlevel", int'(rlevel), 0);
      chk("t6_async_rempty", int'(rempty), 1);
      chk("t6_async_ae", int'(ralmost_empty), 1);
      chk("t6_async_rptr", int'(rptr), 0);
      chk("t6_async_raddr", int'(raddr), 0);
      rinc = 1'b0;
      #1 rrst_n = 1'b1;
      repeat (4) @(posedge rclk);
      #1;
      chk("t6_refill_rlevel", int'(rlevel), 5);
      @(negedge rclk);
      rinc = 1'b1;
      repeat (6) @(negedge rclk);
      rinc = 1'b0;
      chk("t6_empty", int'(rempty), 1);
      chk("t6_raddr_held", int'(raddr), 5);
`ifdef RPTR_UNDERFLOW_EN
      chk("t6_uf_set", int'(runderflow), 1);
`endif
      repeat (3) @(negedge rclk);
`ifdef RPTR_UNDERFLOW_EN
      chk("t6_uf_sticky", int'(runderflow), 1);
`endif
      rrst_n = 1'b0;
      #1;
`ifdef RPTR_UNDERFLOW_EN
      chk("t6_uf_clear", int'(runderflow), 0);
`endif
      chk("t6_final_rptr", int'(rptr), 0);
      chk("t6_final_rempty", int'(rempty), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
